// File: rtl/matrix_unloader_if.sv
// Element stream interface for matrix_unloader.
// master drives data/index/last/valid; slave returns ready.
interface matrix_unloader_if #(
    parameter int ELEM_W = 32,
    parameter int N_ELEM = 16
);
    logic [ELEM_W-1:0]         out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [$clog2(N_ELEM)-1:0] out_index;
    logic                      out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/matrix_unloader.sv
// Snapshots a 512-bit matrix word and streams its 16 elements
// row-major over a valid/ready handshake, then pulses done.
module matrix_unloader #(
    parameter int ELEM_W = 32,
    parameter int N_ELEM = 16
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ELEM_W*N_ELEM-1:0] matrix,
    output logic                     busy,
    output logic                     done,
    matrix_unloader_if.master        m_out
);
    localparam int IW = $clog2(N_ELEM);
    localparam logic [IW-1:0] LAST = IW'(N_ELEM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t r_state, w_state_n;

    logic [N_ELEM-1:0][ELEM_W-1:0] r_shadow;
    logic [N_ELEM-1:0][ELEM_W-1:0] w_matrix;

    logic [ELEM_W-1:0] r_data, w_data_n;
    logic [IW-1:0]     r_idx, w_idx_n, w_idx_inc;
    logic              r_valid, w_valid_n;
    logic              r_last, w_last_n;
    logic              r_busy, w_busy_n;
    logic              r_done, w_done_n;
    logic              w_cap;
    logic              w_xfer;

    assign w_matrix  = matrix;
    assign w_xfer    = r_valid && m_out.out_ready;
    assign w_idx_inc = r_idx + 1'b1;

    // Outputs are computed one cycle ahead and registered.
    always_comb begin
        w_state_n = r_state;
        w_data_n  = r_data;
        w_idx_n   = r_idx;
        w_valid_n = r_valid;
        w_last_n  = r_last;
        w_busy_n  = r_busy;
        w_done_n  = 1'b0;
        w_cap     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_data_n  = '0;
                w_idx_n   = '0;
                w_valid_n = 1'b0;
                w_last_n  = 1'b0;
                w_busy_n  = 1'b0;
                if (start) begin
                    w_cap     = 1'b1;
                    w_state_n = S_SEND;
                    w_data_n  = w_matrix[0];
                    w_valid_n = 1'b1;
                    w_last_n  = (LAST == '0);
                    w_busy_n  = 1'b1;
                end
            end
            S_SEND: begin
                if (w_xfer) begin
                    if (r_idx == LAST) begin
                        w_state_n = S_DONE;
                        w_data_n  = '0;
                        w_idx_n   = '0;
                        w_valid_n = 1'b0;
                        w_last_n  = 1'b0;
                        w_done_n  = 1'b1;
                    end else begin
                        w_idx_n  = w_idx_inc;
                        w_data_n = r_shadow[w_idx_inc];
                        w_last_n = (w_idx_inc == LAST);
                    end
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
                w_data_n  = '0;
                w_idx_n   = '0;
                w_valid_n = 1'b0;
                w_last_n  = 1'b0;
                w_busy_n  = 1'b0;
            end
            default: begin
                w_state_n = S_IDLE;
                w_data_n  = '0;
                w_idx_n   = '0;
                w_valid_n = 1'b0;
                w_last_n  = 1'b0;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_shadow <= '0;
            r_data   <= '0;
            r_idx    <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_cap) r_shadow <= w_matrix;
            r_data  <= w_data_n;
            r_idx   <= w_idx_n;
            r_valid <= w_valid_n;
            r_last  <= w_last_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
        end
    end

    assign m_out.out_data  = r_data;
    assign m_out.out_valid = r_valid;
    assign m_out.out_index = r_idx;
    assign m_out.out_last  = r_last;
    assign busy            = r_busy;
    assign done            = r_done;
endmodule

// File: tb/tb_matrix_unloader.sv
// Directed bench for matrix_unloader: streaming, backpressure,
// snapshot isolation, start-while-busy and reset corner cases.
module tb_matrix_unloader;
    logic         CLK;
    logic         reset;
    logic         start;
    logic [511:0] matrix;
    logic         busy;
    logic         done;

    matrix_unloader_if #(.ELEM_W(32), .N_ELEM(16)) u_if ();

    matrix_unloader #(.ELEM_W(32), .N_ELEM(16)) dut (
        .CLK    (CLK),
        .reset  (reset),
        .start  (start),
        .matrix (matrix),
        .busy   (busy),
        .done   (done),
        .m_out  (u_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        st;
        logic        rdy;
        logic        e_valid;
        logic [3:0]  e_idx;
        logic [31:0] e_data;
        logic        e_last;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t vecs [1:34];

    int n_pass;
    int n_total;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic chk_all(input string nm, input logic v,
                           input logic [3:0] ix, input logic [31:0] d,
                           input logic l, input logic b, input logic dn);
        chk({nm, ".valid"}, 64'(u_if.out_valid), 64'(v));
        chk({nm, ".index"}, 64'(u_if.out_index), 64'(ix));
        chk({nm, ".data"},  64'(u_if.out_data),  64'(d));
        chk({nm, ".last"},  64'(u_if.out_last),  64'(l));
        chk({nm, ".busy"},  64'(busy),           64'(b));
        chk({nm, ".done"},  64'(done),           64'(dn));
    endtask

    logic [511:0] mat_a;
    logic [511:0] mat_b;
    int           busy_cnt;
    int           beats;
    logic         done_given;
    logic         done_seen;

    initial begin
        n_pass  = 0;
        n_total = 0;

        for (int k = 0; k < 16; k++) begin
            mat_a[32*k +: 32] = 32'h1000_0000 + k;
            mat_b[32*k +: 32] = 32'hCAFE_0000 + k;
        end

        // Backpressure vectors: ready toggles 1,0,1,0..., start
        // pulses during SEND (c=5) and during DONE (c=32).
        beats      = 0;
        done_given = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            vecs[c].st  = (c == 5) || (c == 32);
            vecs[c].rdy = (c % 2) == 1;
            if (beats < 16) begin
                vecs[c].e_valid = 1'b1;
                vecs[c].e_idx   = 4'(beats);
                vecs[c].e_data  = 32'hCAFE_0000 + beats;
                vecs[c].e_last  = (beats == 15);
                vecs[c].e_busy  = 1'b1;
                vecs[c].e_done  = 1'b0;
                if (vecs[c].rdy) beats++;
            end else begin
                vecs[c].e_valid = 1'b0;
                vecs[c].e_idx   = 4'd0;
                vecs[c].e_data  = 32'd0;
                vecs[c].e_last  = 1'b0;
                vecs[c].e_busy  = !done_given;
                vecs[c].e_done  = !done_given;
                done_given      = 1'b1;
            end
        end

        reset      = 1'b1;
        start      = 1'b0;
        matrix     = '0;
        u_if.out_ready = 1'b0;
        tick();
        tick();
        chk_all("reset", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        chk_all("idle", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Ready held high.
        matrix         = mat_a;
        u_if.out_ready = 1'b1;
        start          = 1'b1;
        tick();
        start    = 1'b0;
        busy_cnt = 0;
        for (int c = 1; c <= 18; c++) begin
            if (c <= 16)
                chk_all($sformatf("strm%0d", c), 1'b1, 4'(c - 1),
                        32'h1000_0000 + c - 1, c == 16, 1'b1, 1'b0);
            else if (c == 17)
                chk_all("strm_done", 1'b0, 4'd0, 32'd0, 1'b0,
                        1'b1, 1'b1);
            else
                chk_all("strm_idle", 1'b0, 4'd0, 32'd0, 1'b0,
                        1'b0, 1'b0);
            busy_cnt += int'(busy);
            tick();
        end
        chk("strm_busy_cycles", 64'(busy_cnt), 64'd17);

        // Backpressure, snapshot isolation, start while busy.
        u_if.out_ready = 1'b0;
        matrix         = mat_b;
        start          = 1'b1;
        tick();
        start  = 1'b0;
        matrix = '1;
        for (int c = 1; c <= 34; c++) begin
            start          = vecs[c].st;
            u_if.out_ready = vecs[c].rdy;
            chk_all($sformatf("bp%0d", c), vecs[c].e_valid,
                    vecs[c].e_idx, vecs[c].e_data, vecs[c].e_last,
                    vecs[c].e_busy, vecs[c].e_done);
            tick();
        end
        start = 1'b0;

        // Reset after five accepted beats.
        matrix         = mat_a;
        u_if.out_ready = 1'b1;
        start          = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("rst_pre_index", 64'(u_if.out_index), 64'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all("rst_mid", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        done_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            done_seen |= done;
            tick();
        end
        chk("rst_no_done", 64'(done_seen), 64'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("restart", 1'b1, 4'd0, 32'h1000_0000, 1'b0,
                1'b1, 1'b0);
        tick();
        chk("restart_idx1", 64'(u_if.out_index), 64'd1);

        // Reset and start in the same cycle.
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk_all("rst_start", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("rst_start_idle", 1'b0, 4'd0, 32'd0, 1'b0,
                1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/matrix_unloader.md
# matrix_unloader

Streams a 512-bit matrix word out as sixteen 32-bit elements over a valid/ready handshake. It is the read-side counterpart to the matrix memory register in the 32-bit matrix calculator. On a start pulse it snapshots the full 512-bit `matrix` bus, then emits elements 0..15 in row-major order of the 4x4 matrix, one per accepted beat. It signals completion with a one-cycle `done` pulse.

## Interface
- `ELEM_W`, 32, element width in bits
- `N_ELEM`, 16, elements per matrix; `matrix` width is `ELEM_W*N_ELEM`
- `CLK`  input  1  clock; all logic on posedge
- `reset`  input  1  reset; synchronous, active-high
- `start`  input  1  request to unload; sampled only in IDLE
- `matrix`  input  512  source matrix; element k = `matrix[32k+31:32k]`
- `out_data`  output  32  current element
- `out_valid`  output  1  `out_data` / `out_index` / `out_last` are valid
- `out_ready`  input  1  downstream accepts the beat when high with `out_valid`
- `out_index`  output  4  index k of the current element (row = k/4, col = k%4)
- `out_last`  output  1  high when `out_valid` and `out_index == 15`
- `busy`  output  1  high in SEND and DONE
- `done`  output  1  one-cycle pulse after the last beat is accepted

## Operation
- Reset (synchronous, active-high) values:
  - state = IDLE; shadow register = 0.
  - `out_data`, `out_index`, `out_valid`, `out_last`, `busy`, `done` = 0.
- IDLE:
  - If `start`=1, capture `matrix` into a 512-bit shadow register, set index = 0, go to SEND.
  - Otherwise hold all outputs at 0.
- SEND:
  - `out_valid` = 1.
  - `out_data` = shadow element[index].
  - `out_index` = index.
  - `out_last` = (index == 15).
  - A beat transfers in any cycle with `out_valid && out_ready`.
  - On a transfer with index < 15: index increments.
  - On a transfer with index == 15: go to DONE.
  - With no transfer: index and all outputs hold, stable and unchanged.
- DONE (exactly one cycle):
  - `done` = 1, `out_valid` = 0, `busy` = 1.
  - Next state is IDLE.
- `start` outside IDLE is ignored; no queuing.
- Changes on `matrix` after capture have no effect on the stream in progress.
- `out_ready` while `out_valid`=0 has no effect.
- `reset` asserted in any state aborts the transfer: all outputs return to reset values on the next edge, and no `done` pulse is produced.
- `reset` and `start` asserted in the same cycle: reset wins; the next state is IDLE.
- No arithmetic beyond the 4-bit index increment, which never wraps in SEND because 15 exits to DONE.

## Timing
- `start` sampled high at edge t:
  - `out_valid` = 1 and element 0 presented from cycle t+1.
- `out_ready` held at 1:
  - One element per cycle over cycles t+1..t+16.
  - `out_last` is high in cycle t+16.
  - `done` is high in cycle t+17.
  - IDLE in cycle t+18; the earliest next accepted `start` is sampled at edge t+18.
- Each cycle with `out_ready`=0 in SEND extends the sequence by exactly one cycle.
- `busy` is high from t+1 through the `done` cycle inclusive.
- Outputs are registered; no combinational path from `out_ready` to `out_data`.

## Test plan
- Reset mid-stream.
  - Stimulus: assert `reset` in SEND after 5 accepted beats.
  - Response: the next cycle shows `out_valid`=0, `busy`=0, `out_index`=0; `done` never pulses.
  - Stimulus: a new `start` afterwards.
  - Response: element 0 is re-sent.
- Streaming with ready held high.
  - Stimulus: `matrix` element k = 32'h1000_0000+k, `out_ready`=1, one `start` pulse.
  - Response: 16 consecutive beats, data 32'h1000_0000..32'h1000_000F, `out_index` 0..15, `out_last` only on index 15, `done` pulse one cycle after, total 17 cycles `busy`.
- Backpressure.
  - Stimulus: `out_ready` toggling 1,0,1,0...
  - Response: each element is held stable while ready=0, no skipped or duplicated index, `done` at cycle t+32.
- Snapshot isolation.
  - Stimulus: change `matrix` to all-ones one cycle after `start`.
  - Response: streamed data still equals the captured value.
- Start ignored while busy.
  - Stimulus: pulse `start` during SEND and during DONE.
  - Response: no restart; a single `done` pulse; the stream completes normally.
